stuff_reader: RTL and testbench
===============================

Name: stuff_reader

Overview:
- Inbound counterpart of the product-table writer. Accepts a stream of 11-bit product records and rebuilds the five product slot registers p0..p4.
- Record format: productNumber [10:8], count [7:4], price [3:0].
- Records are buffered in shadow registers. They are committed to p0..p4 atomically, and only when a complete, error-free load finishes.
- Sits between the stock-load source (file/loader bench or upstream bus bridge) and the vending core that consumes p0..p4.

Parameters:
- TIMEOUT, default 16: idle cycles allowed between accepted records in LOAD before the load aborts. Legal range 2..255.
- CNT_W, default 8: width of the timeout counter. Must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clock  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- start  input  1  single-cycle request to begin a load; honoured in IDLE only
- in_valid  input  1  record on in_data is valid
- in_data  input  11  record {productNumber[2:0], count[3:0], price[3:0]}
- in_ready  output  1  block can accept a record this cycle
- p0, p1, p2, p3, p4  output  11 each  committed product slots, registered
- busy  output  1  load in progress (any state other than IDLE)
- done  output  1  one-cycle pulse: load committed
- err  output  1  sticky: last load failed; cleared by the next accepted start
- err_code  output  2  00 none, 01 bad slot, 10 duplicate slot, 11 timeout/checksum

Behaviour:
- Interface: one clock domain (clock); reset_n asynchronous active-low.
- Reset values: p0..p4 = 0, in_ready = 0, busy = 0, done = 0, err = 0, err_code = 00, state IDLE. Shadow registers, fill mask, record counter and timeout counter all clear.
- States: IDLE, LOAD, CHECK (feature only), COMMIT.
- IDLE:
  - in_ready = 0.
  - start = 1 -> LOAD on the next edge; clear shadow, mask[4:0], rec_cnt, timeout counter, err and err_code.
- LOAD:
  - in_ready = 1. A handshake is in_valid & in_ready on a rising edge.
  - Slot index = in_data[10:8].
  - Index >= 5: record dropped; err_code = 01 if err_code is still 00.
  - mask[index] already set: record dropped; err_code = 10 if still 00.
  - Otherwise: shadow[index] = in_data and mask[index] = 1.
  - Each handshake increments rec_cnt, whether the record is stored or dropped.
  - Each handshake zeroes the timeout counter. Each non-handshake cycle increments it.
  - Counter reaching TIMEOUT -> COMMIT with err_code = 11 (if still 00).
  - After the 5th handshake -> COMMIT (or CHECK with the optional feature).
- Error precedence: first error wins; later errors do not overwrite err_code.
- COMMIT (exactly 1 cycle, in_ready = 0):
  - If err_code == 00: p0..p4 <= shadow[0..4] and done = 1 for that cycle.
  - Else: p0..p4 unchanged, err = 1, done stays 0.
  - Next state IDLE.
- Latency: done is high in the cycle after the 5th handshake edge (feature off). busy rises the cycle after start and falls the cycle after COMMIT.
- start while busy is ignored. in_valid in IDLE is ignored; no handshake occurs.
- count and price fields are passed through unmodified; zero values are legal.
- Reset mid-load: everything returns to reset values, including p0..p4 = 0. A partial load is never committed.

Optional Feature:
- Macro: STUFF_READER_CHECKSUM_EN.
- Defined:
  - After the 5th record, the block enters CHECK with in_ready = 1 and expects one more word.
  - That word must equal the XOR of the five received in_data words (dropped records included).
  - Mismatch -> err_code = 11 (if still 00). The timeout also applies in CHECK.
  - CHECK -> COMMIT after the checksum handshake; done is high the cycle after that handshake.
- Not defined: no CHECK state; COMMIT follows the 5th record directly.

Test Plan:
- Reset then start; send records 000_0011_0101, 001_0010_0111, 010_0001_0001, 011_0100_0010, 100_1111_1111, one per cycle -> done pulses 1 cycle after the 5th handshake; p0..p4 equal those values; err = 0.
- Same load with 2 idle cycles between records and in_valid toggling -> identical p0..p4; in_ready = 1 throughout LOAD; busy high from start+1 to the COMMIT cycle.
- Second load using slot index 3 twice (no slot 4) -> err = 1, err_code = 10, done = 0; p0..p4 keep the previous load's values.
- Record with index 110 first, then a record with index 1 duplicated -> err_code = 01 (first wins).
- Send 2 records then hold in_valid = 0 for TIMEOUT (16) cycles -> COMMIT, err_code = 11, p unchanged. Assert reset_n = 0 mid-load -> p0..p4 = 0 immediately, in_ready = 0.
- With STUFF_READER_CHECKSUM_EN: correct XOR word -> done; XOR ^ 11'h001 -> err_code = 11, p unchanged.

Source files
------------

// File: rtl/stuff_reader.sv
// stuff_reader: rebuilds the five product slot registers p0..p4 from a stream of 11-bit
// product records {productNumber[2:0], count[3:0], price[3:0]}. Records land in shadow
// registers and are committed atomically only when a complete, error-free load finishes.
//
// Optional feature macro: STUFF_READER_CHECKSUM_EN -- after the fifth record a sixth word
// is expected that must equal the XOR of the five received words.
//
// Ports:
//   clock     rising-edge clock
//   reset_n   asynchronous active-low reset
//   start     single-cycle load request, honoured in IDLE only
//   in_valid  record on in_data is valid
//   in_data   11-bit record
//   in_ready  block can accept a record this cycle
//   p0..p4    committed product slots (registered)
//   busy      load in progress (state other than IDLE)
//   done      one-cycle pulse in the COMMIT cycle of a successful load
//   err       sticky: last load failed; cleared by the next accepted start
//   err_code  00 none, 01 bad slot, 10 duplicate slot, 11 timeout/checksum
module stuff_reader #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic        in_valid,
  input  logic [10:0] in_data,
  output logic        in_ready,
  output logic [10:0] p0,
  output logic [10:0] p1,
  output logic [10:0] p2,
  output logic [10:0] p3,
  output logic [10:0] p4,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code
);

  typedef enum logic [1:0] {StIdle, StLoad, StCheck, StCommit} state_e;

  state_e state_q, state_d;

  logic [10:0]      shadow_q [5];
  logic [10:0]      shadow_d [5];
  logic [10:0]      p_q      [5];
  logic [4:0]       mask_q, mask_d;
  logic [2:0]       rec_cnt_q, rec_cnt_d;
  logic [CNT_W-1:0] tmo_q, tmo_d, tmo_inc;
  logic [1:0]       err_code_q, err_code_d;
  logic             err_q;
`ifdef STUFF_READER_CHECKSUM_EN
  logic [10:0]      xor_q, xor_d;
`endif

  logic       hs;
  logic       tmo_hit;
  logic       commit_entry;
  logic [2:0] idx;

  assign hs      = in_valid & in_ready;
  assign idx     = in_data[10:8];
  assign tmo_inc = tmo_q + CNT_W'(1);
  // Timeout fires on the idle cycle that would bring the counter to TIMEOUT.
  assign tmo_hit = in_ready & ~hs & (tmo_inc == CNT_W'(TIMEOUT));
  assign commit_entry = (state_d == StCommit) && (state_q != StCommit);

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (start) state_d = StLoad;
      end
      StLoad: begin
        if (hs && rec_cnt_q == 3'd4) begin
`ifdef STUFF_READER_CHECKSUM_EN
          state_d = StCheck;
`else
          state_d = StCommit;
`endif
        end else if (tmo_hit) begin
          state_d = StCommit;
        end
      end
`ifdef STUFF_READER_CHECKSUM_EN
      StCheck: begin
        if (hs || tmo_hit) state_d = StCommit;
      end
`endif
      StCommit: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    in_ready = (state_q == StLoad) || (state_q == StCheck);
    busy     = (state_q != StIdle);
    done     = (state_q == StCommit) && (err_code_q == 2'b00);
  end

  // Datapath next-state: shadow fill, slot checks, counters, first-error capture
  always_comb begin
    shadow_d   = shadow_q;
    mask_d     = mask_q;
    rec_cnt_d  = rec_cnt_q;
    tmo_d      = tmo_q;
    err_code_d = err_code_q;
`ifdef STUFF_READER_CHECKSUM_EN
    xor_d      = xor_q;
`endif
    case (state_q)
      StIdle: begin
        if (start) begin
          shadow_d   = '{default: '0};
          mask_d     = '0;
          rec_cnt_d  = '0;
          tmo_d      = '0;
          err_code_d = 2'b00;
`ifdef STUFF_READER_CHECKSUM_EN
          xor_d      = '0;
`endif
        end
      end
      StLoad: begin
        if (hs) begin
          rec_cnt_d = rec_cnt_q + 3'd1;
          tmo_d     = '0;
`ifdef STUFF_READER_CHECKSUM_EN
          xor_d     = xor_q ^ in_data;
`endif
          if (idx >= 3'd5) begin
            if (err_code_q == 2'b00) err_code_d = 2'b01;
          end else if (mask_q[idx]) begin
            if (err_code_q == 2'b00) err_code_d = 2'b10;
          end else begin
            shadow_d[idx] = in_data;
            mask_d[idx]   = 1'b1;
          end
        end else begin
          tmo_d = tmo_inc;
          if (tmo_hit && err_code_q == 2'b00) err_code_d = 2'b11;
        end
      end
`ifdef STUFF_READER_CHECKSUM_EN
      StCheck: begin
        if (hs) begin
          tmo_d = '0;
          if (in_data != xor_q && err_code_q == 2'b00) err_code_d = 2'b11;
        end else begin
          tmo_d = tmo_inc;
          if (tmo_hit && err_code_q == 2'b00) err_code_d = 2'b11;
        end
      end
`endif
      default: ;
    endcase
  end

  // Datapath registers. Slots and err are updated on the edge entering COMMIT so that
  // they are already valid while done is high.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shadow_q   <= '{default: '0};
      p_q        <= '{default: '0};
      mask_q     <= '0;
      rec_cnt_q  <= '0;
      tmo_q      <= '0;
      err_code_q <= 2'b00;
      err_q      <= 1'b0;
`ifdef STUFF_READER_CHECKSUM_EN
      xor_q      <= '0;
`endif
    end else begin
      shadow_q   <= shadow_d;
      mask_q     <= mask_d;
      rec_cnt_q  <= rec_cnt_d;
      tmo_q      <= tmo_d;
      err_code_q <= err_code_d;
`ifdef STUFF_READER_CHECKSUM_EN
      xor_q      <= xor_d;
`endif
      if (state_q == StIdle && start) begin
        err_q <= 1'b0;
      end else if (commit_entry) begin
        if (err_code_d == 2'b00) begin
          p_q <= shadow_d;
        end else begin
          err_q <= 1'b1;
        end
      end
    end
  end

  assign p0       = p_q[0];
  assign p1       = p_q[1];
  assign p2       = p_q[2];
  assign p3       = p_q[3];
  assign p4       = p_q[4];
  assign err      = err_q;
  assign err_code = err_code_q;

endmodule

// File: tb/tb_stuff_reader.sv
module tb_stuff_reader;

  localparam int TIMEOUT = 16;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic        in_valid;
  logic [10:0] in_data;
  logic        in_ready;
  logic [10:0] p0, p1, p2, p3, p4;
  logic        busy, done, err;
  logic [1:0]  err_code;

  int total = 0;
  int bad   = 0;

  stuff_reader #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .p0       (p0),
    .p1       (p1),
    .p2       (p2),
    .p3       (p3),
    .p4       (p4),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .err_code (err_code)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  // Phase of the load: 0 idle, 1 collecting records, 2 awaiting checksum, 3 commit cycle.
  int          ph;
  logic [10:0] words[$];
  int          idle_run;
  bit          tflag, cflag;
  logic [10:0] mp[5];
  bit          merr;

  // err_code is derived from the records seen so far: first bad slot / duplicate in
  // arrival order wins; timeout or checksum only count if no slot error occurred.
  function automatic int first_code();
    bit [7:0] seen = '0;
    int       s;
    foreach (words[i]) begin
      s = int'(words[i][10:8]);
      if (s >= 5) return 1;
      if (seen[s]) return 2;
      seen[s] = 1'b1;
    end
    if (tflag || cflag) return 3;
    return 0;
  endfunction

  function automatic logic [10:0] xor_words();
    logic [10:0] x = '0;
    foreach (words[i]) x = x ^ words[i];
    return x;
  endfunction

  task automatic enter_commit();
    ph = 3;
    if (first_code() == 0) begin
      foreach (words[i]) mp[int'(words[i][10:8])] = words[i];
    end else begin
      merr = 1'b1;
    end
  endtask

  task automatic model_reset();
    ph = 0;
    words.delete();
    idle_run = 0;
    tflag = 1'b0;
    cflag = 1'b0;
    merr = 1'b0;
    for (int i = 0; i < 5; i++) mp[i] = '0;
  endtask

  task automatic model_idle_tick();
    idle_run++;
    if (idle_run == TIMEOUT) begin
      tflag = 1'b1;
      enter_commit();
    end
  endtask

  task automatic model_update(input logic s, input logic v, input logic [10:0] d);
    case (ph)
      0: if (s) begin
        ph = 1;
        words.delete();
        idle_run = 0;
        tflag = 1'b0;
        cflag = 1'b0;
        merr = 1'b0;
      end
      1: if (v) begin
        words.push_back(d);
        idle_run = 0;
        if (words.size() == 5) begin
`ifdef STUFF_READER_CHECKSUM_EN
          ph = 2;
`else
          enter_commit();
`endif
        end
      end else begin
        model_idle_tick();
      end
      2: if (v) begin
        cflag = (d != xor_words());
        enter_commit();
      end else begin
        model_idle_tick();
      end
      default: ph = 0;
    endcase
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    chk("in_ready", 32'(in_ready), 32'(ph == 1 || ph == 2));
    chk("busy", 32'(busy), 32'(ph != 0));
    chk("done", 32'(done), 32'(ph == 3 && first_code() == 0));
    chk("err", 32'(err), 32'(merr));
    chk("err_code", 32'(err_code), 32'(first_code()));
    chk("p0", 32'(p0), 32'(mp[0]));
    chk("p1", 32'(p1), 32'(mp[1]));
    chk("p2", 32'(p2), 32'(mp[2]));
    chk("p3", 32'(p3), 32'(mp[3]));
    chk("p4", 32'(p4), 32'(mp[4]));
  endtask

  // Drive one cycle (called just after a falling edge), then compare at the next one.
  task automatic step(input logic s, input logic v, input logic [10:0] d);
    start    = s;
    in_valid = v;
    in_data  = d;
    @(posedge clock);
    model_update(s, v, d);
    @(negedge clock);
    compare();
  endtask

  logic [10:0] rec[5];

  task automatic send_load(input int gap, input bit bad_ck, input bit exp_done);
    logic [10:0] x;
    x = '0;
    step(1'b1, 1'b0, 11'($urandom));
    for (int i = 0; i < 5; i++) begin
      repeat (gap) step(1'b0, 1'b0, 11'($urandom));
      step(1'b0, 1'b1, rec[i]);
      x = x ^ rec[i];
    end
`ifdef STUFF_READER_CHECKSUM_EN
    repeat (gap) step(1'b0, 1'b0, 11'($urandom));
    step(1'b0, 1'b1, bad_ck ? (x ^ 11'h001) : x);
`else
    if (bad_ck) x = '0;
`endif
    chk("done_latency", 32'(done), 32'(exp_done));
  endtask

  task automatic rand_load();
    logic [10:0] r[5];
    int          perm[5];
    int          j, k, t, gap;
    logic [10:0] x;
    for (int i = 0; i < 5; i++) perm[i] = i;
    for (int i = 4; i > 0; i--) begin
      j = int'($urandom_range(i, 0));
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    for (int i = 0; i < 5; i++) r[i] = {3'(perm[i]), 8'($urandom)};
    if ($urandom_range(5, 0) == 0) begin
      k = int'($urandom_range(4, 0));
      if ($urandom_range(1, 0) == 0) r[k][10:8] = 3'($urandom_range(7, 5));
      else r[k][10:8] = r[(k + 1) % 5][10:8];
    end
    step(1'b1, 1'b0, 11'($urandom));
    x = '0;
    for (int i = 0; i < 5; i++) begin
      gap = int'($urandom_range(2, 0));
      if ($urandom_range(9, 0) == 0) gap = TIMEOUT + 1;
      repeat (gap) step(1'($urandom_range(3, 0) == 0), 1'b0, 11'($urandom));
      step(1'b0, 1'b1, r[i]);
      x = x ^ r[i];
    end
`ifdef STUFF_READER_CHECKSUM_EN
    step(1'b0, 1'b1, ($urandom_range(3, 0) == 0) ? (x ^ 11'h001) : x);
`endif
    repeat (3) step(1'b0, 1'($urandom_range(1, 0)), 11'($urandom));
  endtask

  initial begin
    reset_n  = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    model_reset();
    repeat (2) @(negedge clock);
    chk("rst_p0", 32'(p0), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_err_code", 32'(err_code), 32'h0);
    reset_n = 1'b1;
    step(1'b0, 1'b1, 11'h7FF);  // in_valid in IDLE must be ignored

    // Back-to-back load of the reference records.
    rec[0] = 11'h035; rec[1] = 11'h127; rec[2] = 11'h211; rec[3] = 11'h342; rec[4] = 11'h4FF;
    send_load(0, 1'b0, 1'b1);
    chk("lit_p0", 32'(p0), 32'h035);
    chk("lit_p1", 32'(p1), 32'h127);
    chk("lit_p2", 32'(p2), 32'h211);
    chk("lit_p3", 32'(p3), 32'h342);
    chk("lit_p4", 32'(p4), 32'h4FF);
    step(1'b1, 1'b0, '0);  // start during COMMIT is ignored
    chk("lit_idle_busy", 32'(busy), 32'h0);
    chk("lit_err0", 32'(err), 32'h0);

    // Same load with idle gaps.
    send_load(2, 1'b0, 1'b1);
    step(1'b0, 1'b0, '0);

    // Slot 3 twice, no slot 4.
    rec[4] = 11'h3AB;
    send_load(0, 1'b0, 1'b0);
    chk("lit_dup_code", 32'(err_code), 32'h2);
    chk("lit_dup_err", 32'(err), 32'h1);
    chk("lit_dup_p4", 32'(p4), 32'h4FF);
    step(1'b0, 1'b0, '0);

    // Bad index first, then a duplicate: first error wins.
    rec[0] = 11'h612; rec[1] = 11'h127; rec[2] = 11'h127; rec[3] = 11'h211; rec[4] = 11'h342;
    send_load(1, 1'b0, 1'b0);
    chk("lit_idx_code", 32'(err_code), 32'h1);
    step(1'b0, 1'b0, '0);

    // Two records then silence until the timeout.
    step(1'b1, 1'b0, '0);
    step(1'b0, 1'b1, 11'h001);
    step(1'b0, 1'b1, 11'h102);
    repeat (TIMEOUT) step(1'b0, 1'b0, 11'($urandom));
    chk("lit_tmo_code", 32'(err_code), 32'h3);
    chk("lit_tmo_done", 32'(done), 32'h0);
    chk("lit_tmo_p1", 32'(p1), 32'h127);
    step(1'b0, 1'b0, '0);

`ifdef STUFF_READER_CHECKSUM_EN
    rec[0] = 11'h035; rec[1] = 11'h127; rec[2] = 11'h211; rec[3] = 11'h342; rec[4] = 11'h4EE;
    send_load(0, 1'b1, 1'b0);
    chk("lit_ck_code", 32'(err_code), 32'h3);
    chk("lit_ck_p4", 32'(p4), 32'h4FF);
    step(1'b0, 1'b0, '0);
    send_load(0, 1'b0, 1'b1);
    chk("lit_ck_ok_p4", 32'(p4), 32'h4EE);
    step(1'b0, 1'b0, '0);
`endif

    for (int n = 0; n < 60; n++) rand_load();
    repeat (TIMEOUT + 8) step(1'b0, 1'b0, 11'($urandom));

    // Reset in the middle of a load.
    rec[0] = 11'h035; rec[1] = 11'h127; rec[2] = 11'h211; rec[3] = 11'h342; rec[4] = 11'h4FF;
    send_load(0, 1'b0, 1'b1);
    step(1'b0, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    step(1'b0, 1'b1, 11'h0AA);
    step(1'b0, 1'b1, 11'h1BB);
    reset_n = 1'b0;
    #1;
    chk("lit_mid_rst_p0", 32'(p0), 32'h0);
    chk("lit_mid_rst_p4", 32'(p4), 32'h0);
    chk("lit_mid_rst_ready", 32'(in_ready), 32'h0);
    chk("lit_mid_rst_busy", 32'(busy), 32'h0);
    model_reset();
    #2;
    reset_n = 1'b1;
    repeat (3) step(1'b0, 1'b1, 11'($urandom));
    rand_load();
    repeat (TIMEOUT + 8) step(1'b0, 1'b0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
